// File: rtl/btc_job_ctrl_pkg.sv
// btc_pkg: shared states, sizes and byte-swap helper for the mining job controller
package btc_pkg;
  typedef enum logic [2:0] {IDLE, FREQ, FREL, LAUNCH, WAIT, CHECK, FOUND, EXHAUST} state_t;
  localparam int HDR_BYTES = 80;
  localparam int NONCE_OFS = 76;
  localparam int HASH_BITS = 256;
  function automatic logic [HASH_BITS-1:0] bswap256(input logic [HASH_BITS-1:0] h);
    logic [HASH_BITS-1:0] r;
    for (int i = 0; i < HASH_BITS / 8; i++) r[8*i +: 8] = h[HASH_BITS-8-8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/btc_job_ctrl_if.sv
// btc_job_ctrl_if: byte-serial host fetch port plus SHA-256d core launch/result port
interface btc_job_ctrl_if #(parameter int HDR_BYTES = btc_pkg::HDR_BYTES);
  logic                   ext_rq;
  logic [7:0]             ext_addr;
  logic                   ext_rdy;
  logic [7:0]             ext_data;
  logic                   core_start;
  logic [8*HDR_BYTES-1:0] core_hdr;
  logic                   core_done;
  logic [255:0]           core_hash;
  modport master (output ext_rq, ext_addr, core_start, core_hdr, input ext_rdy, ext_data, core_done, core_hash);
  modport slave (input ext_rq, ext_addr, core_start, core_hdr, output ext_rdy, ext_data, core_done, core_hash);
endinterface

// File: rtl/btc_target_cmp.sv
// btc_target_cmp: passes when the displayed (byte-reversed) hash has at least zbits leading zeros
module btc_target_cmp
  import btc_pkg::*;
(
  input  logic [HASH_BITS-1:0] hash,
  input  logic [7:0]           zbits,
  output logic                 pass
);
  logic [HASH_BITS-1:0] d;
  assign d = bswap256(hash);
  assign pass = (d & ~({HASH_BITS{1'b1}} >> zbits)) == '0;
endmodule

// File: rtl/btc_job_ctrl.sv
// btc_job_ctrl: fetches a block header, then sweeps nonces through the SHA-256d core until hit, exhaustion or abort
module btc_job_ctrl #(
  parameter int HDR_BYTES = btc_pkg::HDR_BYTES,
  parameter int NONCE_OFS = btc_pkg::NONCE_OFS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            zbits,
  btc_job_ctrl_if.master        bus,
  output logic                  busy,
  output logic                  found,
  output logic                  exhausted,
  output logic [31:0]           nonce
);
  import btc_pkg::*;
  state_t state, state_nx;
  logic [8*HDR_BYTES-1:0] hdr;
  logic [7:0] cnt, zb;
  logic pass, pass_r, idle_like, last;
  assign idle_like = state inside {IDLE, FOUND, EXHAUST};
  assign last = cnt == 8'(HDR_BYTES - 1);
  btc_target_cmp u_cmp (.hash(bus.core_hash), .zbits(zb), .pass(pass));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FOUND, EXHAUST: state_nx = start ? FREQ : state;
      FREQ:   state_nx = bus.ext_rdy ? FREL : FREQ;
      FREL:   state_nx = bus.ext_rdy ? FREL : last ? LAUNCH : FREQ;
      LAUNCH: state_nx = WAIT;
      WAIT:   state_nx = bus.core_done ? CHECK : WAIT;
      CHECK:  state_nx = pass_r ? FOUND : &nonce ? EXHAUST : LAUNCH;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  assign bus.ext_rq     = state == FREQ;
  assign bus.ext_addr   = cnt;
  assign bus.core_start = state == LAUNCH;
  assign busy           = !idle_like;
  assign found          = state == FOUND;
  assign exhausted      = state == EXHAUST;
  // The nonce field of the header is always overlaid by the live nonce register
  always_comb begin
    bus.core_hdr = hdr;
    for (int k = 0; k < 4; k++) bus.core_hdr[8*(HDR_BYTES-1-NONCE_OFS-k) +: 8] = nonce[8*k +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hdr    <= '0;
      cnt    <= '0;
      zb     <= '0;
      pass_r <= 1'b0;
      nonce  <= '0;
    end else begin
      state <= state_nx;
      if (idle_like && state_nx == FREQ) begin
        cnt <= '0;
        zb  <= zbits;
      end
      if (state == FREQ && state_nx == FREL) hdr[8*(HDR_BYTES-1-int'(cnt)) +: 8] <= bus.ext_data;
      if (state == FREL && state_nx == FREQ) cnt <= cnt + 8'd1;
      if (state == FREL && state_nx == LAUNCH)
        for (int k = 0; k < 4; k++) nonce[8*k +: 8] <= hdr[8*(HDR_BYTES-1-NONCE_OFS-k) +: 8];
      if (state == WAIT && bus.core_done) pass_r <= pass;
      if (state == CHECK && state_nx == LAUNCH) nonce <= nonce + 32'd1;
    end
  end
endmodule

// File: tb/tb_btc_job_ctrl.sv
// tb_btc_job_ctrl: directed and randomized jobs against a host/core model with a nonce-sweep reference
module tb_btc_job_ctrl;
  localparam int HB = 80;
  logic clk = 1'b0;
  logic rst, start, abort;
  logic [7:0] zbits;
  logic busy, found, exhausted;
  logic [31:0] nonce;
  btc_job_ctrl_if #(.HDR_BYTES(HB)) bus ();
  btc_job_ctrl #(.HDR_BYTES(HB), .NONCE_OFS(76)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .zbits(zbits), .bus(bus),
    .busy(busy), .found(found), .exhausted(exhausted), .nonce(nonce)
  );
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int mode = 0, lat = 2;
  logic [7:0] hb [HB];
  logic [639:0] l_hdr [$];
  logic [255:0] l_hash [$];
  logic [255:0] gen_hash;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // leading zero bits of the displayed digest: SHA byte 31 (core_hash[7:0]) is shown first
  function automatic int lz(input logic [255:0] h);
    int n = 0;
    for (int b = 0; b < 32; b++)
      for (int j = 7; j >= 0; j--) begin
        if (h[8*b+j]) return n;
        n++;
      end
    return n;
  endfunction

  function automatic logic [639:0] exp_hdr(input logic [31:0] n);
    logic [639:0] r;
    for (int i = 0; i < HB; i++) r[8*(HB-1-i) +: 8] = (i >= 76) ? n[8*(i-76) +: 8] : hb[i];
    return r;
  endfunction

  initial begin : core_model
    logic [255:0] dsp;
    dsp = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    for (int i = 0; i < 32; i++) gen_hash[8*i +: 8] = dsp[8*(31-i) +: 8];
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    forever begin
      @(negedge clk);
      if (bus.core_start === 1'b1) begin
        logic [255:0] h;
        h = (mode == 0) ? gen_hash : (mode == 1) ? '1 :
            {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        l_hdr.push_back(bus.core_hdr);
        l_hash.push_back(h);
        repeat (lat) @(negedge clk);
        bus.core_done = 1'b1;
        bus.core_hash = h;
        @(negedge clk);
        bus.core_done = 1'b0;
        bus.core_hash = '0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic rand_hdr(input logic [31:0] n);
    for (int i = 0; i < HB; i++) hb[i] = 8'($urandom);
    for (int k = 0; k < 4; k++) hb[76+k] = n[8*k +: 8];
  endtask

  task automatic go(input logic [7:0] z);
    l_hdr.delete();
    l_hash.delete();
    zbits = z;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    zbits = 8'($urandom);
  endtask

  task automatic fetch(input int stall_at);
    for (int i = 0; i < HB; i++) begin
      int t = 0;
      while (bus.ext_rq !== 1'b1 && t < 10) begin
        @(negedge clk);
        t++;
      end
      chk("fetch_rq", bus.ext_rq, 1);
      chk("fetch_addr", bus.ext_addr, i);
      if (bus.ext_rq !== 1'b1) return;
      if (i == stall_at)
        repeat (5) begin
          @(negedge clk);
          chk("stall_rq", bus.ext_rq, 1);
          chk("stall_addr", bus.ext_addr, i);
        end
      bus.ext_data = hb[i];
      bus.ext_rdy = 1'b1;
      @(negedge clk);
      bus.ext_rdy = 1'b0;
      bus.ext_data = 8'($urandom);
    end
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (busy === 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("done_in_time", busy, 0);
  endtask

  task automatic wait_launch(input int budget);
    int t = 0;
    while (bus.core_start !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("launch_in_time", bus.core_start, 1);
  endtask

  // Reference: nonces sweep upward from the header value; stop at first digest meeting z or at FFFFFFFF
  task automatic verify(input logic [7:0] z);
    logic [31:0] n0;
    int k = 0;
    logic p = 1'b0;
    n0 = {hb[79], hb[78], hb[77], hb[76]};
    while (k < l_hash.size()) begin
      chk("launch_hdr", l_hdr[k] == exp_hdr(n0 + 32'(k)), 1);
      p = lz(l_hash[k]) >= int'(z);
      if (p || n0 + 32'(k) == 32'hFFFFFFFF) break;
      k++;
    end
    chk("launches", l_hash.size(), k + 1);
    chk("found", found, p);
    chk("exhausted", exhausted, !p);
    chk("nonce", nonce, n0 + 32'(k));
  endtask

  initial begin : main
    logic [639:0] keep, now;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    zbits = '0;
    bus.ext_rdy = 1'b0;
    bus.ext_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_found", found, 0);
    chk("rst_exh", exhausted, 0);
    chk("rst_nonce", nonce, 0);
    chk("rst_rq", bus.ext_rq, 0);
    chk("rst_cstart", bus.core_start, 0);
    rst = 1'b0;
    @(negedge clk);

    // genesis header with a stalled byte 40, difficulty 43 passes on the first nonce
    mode = 0; lat = 2;
    rand_hdr(32'h7C2BAC1D);
    go(8'd43);
    fetch(40);
    wait_done(200);
    verify(8'd43);
    chk("gen_found", found, 1);
    chk("gen_nonce", nonce, 32'h7C2BAC1D);
    chk("gen_launches", l_hash.size(), 1);

    // difficulty 44 fails; second launch carries nonce+1
    go(8'd44);
    fetch(-1);
    for (int t = 0; t < 100 && l_hdr.size() < 2; t++) @(negedge clk);
    chk("g44_launches", l_hdr.size() >= 2, 1);
    if (l_hdr.size() >= 2) chk("g44_hdr", l_hdr[1] == exp_hdr(32'h7C2BAC1E), 1);
    chk("g44_nonce", nonce, 32'h7C2BAC1E);
    chk("g44_busy", busy, 1);
    keep = exp_hdr(32'h0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_found", found, 0);
    now = bus.core_hdr;
    chk("abort_keep", now[639:32] == keep[639:32], 1);
    repeat (10) @(negedge clk);

    // last nonce, never-passing digest
    mode = 1;
    rand_hdr(32'hFFFFFFFF);
    go(8'd8);
    fetch(-1);
    wait_done(200);
    verify(8'd8);
    chk("exh_flag", exhausted, 1);
    chk("exh_nonce", nonce, 32'hFFFFFFFF);
    chk("exh_launches", l_hash.size(), 1);

    // abort coinciding with a passing core_done
    mode = 0; lat = 3;
    rand_hdr(32'h7C2BAC1D);
    go(8'd43);
    fetch(-1);
    wait_launch(20);
    repeat (lat) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done_busy", busy, 0);
    chk("abort_done_found", found, 0);
    repeat (3) @(negedge clk);
    chk("abort_done_found2", found, 0);
    chk("abort_done_exh", exhausted, 0);

    // asynchronous reset while waiting on the core
    mode = 1; lat = 10;
    rand_hdr(32'($urandom));
    go(8'd8);
    fetch(-1);
    wait_launch(20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_rq", bus.ext_rq, 0);
    chk("arst_cstart", bus.core_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_nonce", nonce, 0);
    chk("arst_addr", bus.ext_addr, 0);
    chk("arst_hdr", bus.core_hdr == '0, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    mode = 2; lat = 1;
    rand_hdr(32'($urandom));
    go(8'd3);
    fetch(-1);
    wait_done(2000);
    verify(8'd3);

    // randomized jobs, some starting just below nonce exhaustion
    for (int r = 0; r < 6; r++) begin
      logic [7:0] z;
      mode = 2;
      lat = $urandom_range(1, 4);
      z = 8'($urandom_range(0, 5));
      rand_hdr((r % 2 == 1) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : 32'($urandom));
      go(z);
      fetch((r == 2) ? int'($urandom_range(0, HB - 1)) : -1);
      wait_done(6000);
      verify(z);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
